// File: rtl/demux_pkg.sv
// Shared route encodings for the 1-to-3 distributor and its 3-input selector counterpart.
package demux_pkg;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_C    = 2'b10,
        SEL_DROP = 2'b11
    } sel_e;

    localparam int unsigned SEL_W    = 2;
    localparam int unsigned NUM_CHAN = 3;

endpackage

// File: rtl/demux_chan_buf.sv
// Per-channel synchronous FIFO; head entry is presented on rdata.
module demux_chan_buf #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage, pointers (wrap modulo DEPTH) and occupancy; reset clears entries so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_3.sv
// Registered 1-to-3 distributor with independent per-channel buffers and a saturating drop counter.
module demux_3
    import demux_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data_a,
    output logic             out_valid_a,
    input  logic             out_ready_a,
    output logic [OUT_W-1:0] out_data_b,
    output logic             out_valid_b,
    input  logic             out_ready_b,
    output logic [OUT_W-1:0] out_data_c,
    output logic             out_valid_c,
    input  logic             out_ready_c,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned BCNT_W = $clog2(DEPTH) + 1;

    sel_e              sel;
    logic              accept;
    logic [OUT_W-1:0]  word;
    logic [BCNT_W-1:0] count_a, count_b, count_c;
    logic              full_a, full_b, full_c;
    logic              empty_a, empty_b, empty_c;
    logic              push_a, push_b, push_c;

    assign sel    = sel_e'(in_sel);
    assign accept = in_valid && in_ready;
    assign word   = in_data[OUT_W-1:0];

    // Upper input bits are truncated by design.
    if (IN_W > OUT_W) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^in_data[IN_W-1:OUT_W];
    end

    // Ready depends only on the selected channel's registered occupancy; drops are always accepted.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            SEL_A:   in_ready = (count_a < BCNT_W'(DEPTH));
            SEL_B:   in_ready = (count_b < BCNT_W'(DEPTH));
            SEL_C:   in_ready = (count_c < BCNT_W'(DEPTH));
            default: in_ready = 1'b1;
        endcase
    end

    assign push_a = accept && (sel == SEL_A) && !full_a;
    assign push_b = accept && (sel == SEL_B) && !full_b;
    assign push_c = accept && (sel == SEL_C) && !full_c;

    assign out_valid_a = !empty_a;
    assign out_valid_b = !empty_b;
    assign out_valid_c = !empty_c;

    demux_chan_buf #(.W(OUT_W), .DEPTH(DEPTH)) u_buf_a (
        .clk(clk), .rst(rst), .push(push_a), .wdata(word), .pop(out_ready_a),
        .rdata(out_data_a), .count(count_a), .full(full_a), .empty(empty_a)
    );

    demux_chan_buf #(.W(OUT_W), .DEPTH(DEPTH)) u_buf_b (
        .clk(clk), .rst(rst), .push(push_b), .wdata(word), .pop(out_ready_b),
        .rdata(out_data_b), .count(count_b), .full(full_b), .empty(empty_b)
    );

    demux_chan_buf #(.W(OUT_W), .DEPTH(DEPTH)) u_buf_c (
        .clk(clk), .rst(rst), .push(push_c), .wdata(word), .pop(out_ready_c),
        .rdata(out_data_c), .count(count_c), .full(full_c), .empty(empty_c)
    );

    // Saturating count of words accepted on the drop route.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && (sel == SEL_DROP) && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_3.sv
// Directed and randomized bench for demux_3 against a queue-based reference model.
module tb_demux_3;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;
    localparam int          DROP_MAX = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  in_data = '0;
    logic [1:0]       in_sel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data_a, out_data_b, out_data_c;
    logic             out_valid_a, out_valid_b, out_valid_c;
    logic             out_ready_a = 1'b0, out_ready_b = 1'b0, out_ready_c = 1'b0;
    logic [CNT_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel, a saturating drop tally, and a
    // flag per channel meaning "reset since last write, head reads zero".
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];
    int         drops = 0;
    bit         fresh_a = 1'b1, fresh_b = 1'b1, fresh_c = 1'b1;

    demux_3 #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data_a(out_data_a), .out_valid_a(out_valid_a), .out_ready_a(out_ready_a),
        .out_data_b(out_data_b), .out_valid_b(out_valid_b), .out_ready_b(out_ready_b),
        .out_data_c(out_data_c), .out_valid_c(out_valid_c), .out_ready_c(out_ready_c),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input logic [1:0] s);
        case (s)
            2'd0:    return qa.size() < int'(DEPTH);
            2'd1:    return qb.size() < int'(DEPTH);
            2'd2:    return qc.size() < int'(DEPTH);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_outs();
        chk("valid_a", out_valid_a, qa.size() > 0);
        chk("valid_b", out_valid_b, qb.size() > 0);
        chk("valid_c", out_valid_c, qc.size() > 0);
        if (qa.size() > 0) chk("data_a", out_data_a, qa[0]);
        else if (fresh_a)  chk("data_a_rst", out_data_a, 0);
        if (qb.size() > 0) chk("data_b", out_data_b, qb[0]);
        else if (fresh_b)  chk("data_b_rst", out_data_b, 0);
        if (qc.size() > 0) chk("data_c", out_data_c, qc[0]);
        else if (fresh_c)  chk("data_c_rst", out_data_c, 0);
        chk("drop_count", drop_count, drops);
    endtask

    // One clock: apply inputs, check in_ready, advance model at the edge, check outputs.
    task automatic cyc(input bit r, input bit v, input logic [1:0] s, input logic [15:0] d,
                       input bit ra, input bit rb, input bit rc);
        bit rdy;
        rst = r; in_valid = v; in_sel = s; in_data = d;
        out_ready_a = ra; out_ready_b = rb; out_ready_c = rc;
        #1;
        rdy = model_ready(s);
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (r) begin
            qa.delete(); qb.delete(); qc.delete();
            drops = 0;
            fresh_a = 1'b1; fresh_b = 1'b1; fresh_c = 1'b1;
        end else begin
            if (ra && qa.size() > 0) void'(qa.pop_front());
            if (rb && qb.size() > 0) void'(qb.pop_front());
            if (rc && qc.size() > 0) void'(qc.pop_front());
            if (v && rdy) begin
                case (s)
                    2'd0: begin qa.push_back(d[7:0]); fresh_a = 1'b0; end
                    2'd1: begin qb.push_back(d[7:0]); fresh_b = 1'b0; end
                    2'd2: begin qc.push_back(d[7:0]); fresh_c = 1'b0; end
                    default: if (drops < DROP_MAX) drops++;
                endcase
            end
        end
        #1;
        check_outs();
    endtask

    initial begin
        // Reset, then idle with every route selected.
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0);
        cyc(1, 0, 2'd0, 16'h0000, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            cyc(0, 0, 2'(s), 16'hFFFF, 1, 1, 1);
            chk("idle_ready", in_ready, 1);
        end

        // Routing and truncation.
        cyc(0, 1, 2'd0, 16'h1202, 1, 1, 1);
        chk("route_a", out_data_a, 8'h02);
        cyc(0, 1, 2'd1, 16'h3404, 1, 1, 1);
        chk("route_b", out_data_b, 8'h04);
        cyc(0, 1, 2'd2, 16'h5601, 1, 1, 1);
        chk("route_c", out_data_c, 8'h01);
        cyc(0, 0, 2'd0, 16'h0000, 1, 1, 1);

        // Back-pressure on A.
        cyc(0, 1, 2'd0, 16'h000A, 0, 1, 1);
        cyc(0, 1, 2'd0, 16'h000B, 0, 1, 1);
        cyc(0, 0, 2'd0, 16'h0000, 0, 1, 1);
        chk("bp_ready_a", in_ready, 0);
        cyc(0, 0, 2'd1, 16'h0000, 0, 1, 1);
        chk("bp_ready_b", in_ready, 1);
        cyc(0, 1, 2'd0, 16'h000C, 1, 1, 1);
        chk("bp_head_after_pop", out_data_a, 8'h0B);
        cyc(0, 1, 2'd0, 16'h000C, 0, 1, 1);
        chk("bp_head_hold", out_data_a, 8'h0B);
        cyc(0, 0, 2'd0, 16'h0000, 1, 1, 1);
        chk("bp_third", out_data_a, 8'h0C);
        cyc(0, 0, 2'd0, 16'h0000, 1, 1, 1);
        chk("bp_drained", out_valid_a, 0);

        // Simultaneous push and pop with one entry held.
        cyc(0, 1, 2'd0, 16'h0011, 0, 1, 1);
        cyc(0, 1, 2'd0, 16'h0055, 1, 1, 1);
        chk("pp_valid", out_valid_a, 1);
        chk("pp_head", out_data_a, 8'h55);
        cyc(0, 0, 2'd0, 16'h0000, 1, 1, 1);

        // Drops and saturation.
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'd3, 16'(i), 1, 1, 1);
        chk("drop3", drop_count, 3);
        for (int i = 0; i < 257; i++) cyc(0, 1, 2'd3, 16'(i), 0, 0, 0);
        chk("drop_sat", drop_count, 255);

        // Reset with A and B full and a word presented.
        cyc(0, 1, 2'd0, 16'h00A1, 0, 0, 0);
        cyc(0, 1, 2'd0, 16'h00A2, 0, 0, 0);
        cyc(0, 1, 2'd1, 16'h00B1, 0, 0, 0);
        cyc(0, 1, 2'd1, 16'h00B2, 0, 0, 0);
        cyc(1, 1, 2'd0, 16'hBEEF, 1, 0, 0);
        chk("rst_valid_a", out_valid_a, 0);
        chk("rst_drop", drop_count, 0);
        cyc(0, 0, 2'd0, 16'h0000, 0, 0, 0);
        chk("rst_not_stored", out_valid_a, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 16'($urandom),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) < 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
